// File: rtl/axis_pkt_rr_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel streams packed side by side.
// The arbiter takes its inputs as a multi-lane slave and drives a single-lane master.
interface axis_pkt_rr_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
);
    logic [LANES*DATA_WIDTH-1:0]   tdata;
    logic [LANES*DATA_WIDTH/8-1:0] tstrb;
    logic [LANES*USER_WIDTH-1:0]   tuser;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tlast;
    logic [LANES-1:0]              tready;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream inputs onto one output.
// A port owns the output from its grant until its tlast beat is accepted.
module axis_pkt_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    axis_pkt_rr_arbiter_if.slave    s_axis,
    axis_pkt_rr_arbiter_if.master   m_axis,
    output logic [2:0]              grant,
    output logic                    busy,
    output logic [NUM_PORTS-1:0]    pkt_done
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [2:0]             grant_next;
    logic [2:0]             last_grant;
    logic [2:0]             last_grant_next;
    logic [NUM_PORTS-1:0]   pkt_done_next;
    logic                   req_found;
    logic                   last_accepted;

    assign busy = (state == BUSY);

    // Output mux follows the registered grant; valid/ready are only opened while busy.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tstrb  = '0;
        m_axis.tuser  = '0;
        m_axis.tlast  = '0;
        m_axis.tvalid = '0;
        s_axis.tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == 3'(i)) begin
                m_axis.tdata     = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis.tstrb     = s_axis.tstrb[i*STRB_WIDTH +: STRB_WIDTH];
                m_axis.tuser     = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
                m_axis.tlast[0]  = s_axis.tlast[i];
                m_axis.tvalid[0] = busy & s_axis.tvalid[i];
                s_axis.tready[i] = busy & m_axis.tready[0];
            end
        end
    end

    assign last_accepted = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];

    // Next-state logic; the search starts one past the previous owner so priority rotates.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        pkt_done_next   = '0;
        req_found       = 1'b0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (!req_found && s_axis.tvalid[i] &&
                            ((int'(last_grant) + k) % NUM_PORTS) == i) begin
                            req_found  = 1'b1;
                            grant_next = 3'(i);
                        end
                    end
                end
                if (req_found) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_accepted) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        pkt_done_next[i] = (grant == 3'(i));
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset hands port 0 the first turn by parking last_grant on the top port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 3'd0;
            last_grant <= 3'(NUM_PORTS - 1);
            pkt_done   <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            pkt_done   <= pkt_done_next;
        end
    end

endmodule
